// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank command initiator: opcode encoding,
// FSM state type and default geometry of the 16x32 bank.
package regbank_pkg;

   localparam int unsigned DEF_NUM_REGS = 16;
   localparam int unsigned DEF_ADDR_W   = 4;
   localparam int unsigned DEF_DATA_W   = 32;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_READ2 = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam logic [1:0] OP_DUMP  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RSP,
      S_DRD,
      S_DRSP
   } state_e;

endpackage

// File: rtl/regbank_master.sv
// Command-driven initiator for the register bank: turns READ2/WRITE/DUMP commands
// into bank port activity and returns captured contents on a valid/ready channel.
module regbank_master
   import regbank_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_ra,
   input  logic [ADDR_W-1:0] cmd_rb,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data_a,
   output logic [DATA_W-1:0] rsp_data_b,
   output logic [ADDR_W-1:0] rsp_idx,
   output logic              rsp_last,
   output logic [ADDR_W-1:0] rb_read_reg1,
   output logic [ADDR_W-1:0] rb_read_reg2,
   input  logic [DATA_W-1:0] rb_data_out1,
   input  logic [DATA_W-1:0] rb_data_out2,
   output logic [ADDR_W-1:0] rb_write_reg,
   output logic [DATA_W-1:0] rb_write_data,
   output logic              rb_write_enable
);

   localparam logic [ADDR_W-2:0] K_LAST = (ADDR_W-1)'(NUM_REGS / 2 - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-2:0]   k_q, k_d, k_inc;
   logic [ADDR_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
   logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                we_q, we_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                last_q, last_d;

   assign k_inc = k_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         we_q      <= 1'b0;
         valid_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
         we_q      <= we_d;
         valid_q   <= valid_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      we_d      = 1'b0;
      valid_d   = valid_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      last_d    = last_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_READ2: begin
                     rd1_d   = cmd_ra;
                     rd2_d   = cmd_rb;
                     state_d = S_RD;
                  end
                  OP_WRITE: begin
                     wr_reg_d  = cmd_ra;
                     wr_data_d = cmd_wdata;
                     we_d      = 1'b1;
                     state_d   = S_WR;
                  end
                  OP_DUMP: begin
                     k_d     = '0;
                     rd1_d   = ADDR_W'(0);
                     rd2_d   = ADDR_W'(1);
                     state_d = S_DRD;
                  end
                  default: ;
               endcase
            end
         end
         S_RD: begin
            a_d     = rb_data_out1;
            b_d     = rb_data_out2;
            idx_d   = rd1_q;
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = S_RSP;
         end
         S_WR: begin
            a_d     = wr_data_q;
            b_d     = '0;
            idx_d   = wr_reg_q;
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_DRD: begin
            a_d     = rb_data_out1;
            b_d     = rb_data_out2;
            idx_d   = {k_q, 1'b0};
            last_d  = (k_q == K_LAST);
            valid_d = 1'b1;
            state_d = S_DRSP;
         end
         S_DRSP: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = S_IDLE;
               end else begin
                  k_d     = k_inc;
                  rd1_d   = {k_inc, 1'b0};
                  rd2_d   = {k_inc, 1'b1};
                  state_d = S_DRD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready       = (state_q == S_IDLE);
   assign rsp_valid       = valid_q;
   assign rsp_data_a      = a_q;
   assign rsp_data_b      = b_q;
   assign rsp_idx         = idx_q;
   assign rsp_last        = last_q;
   assign rb_read_reg1    = rd1_q;
   assign rb_read_reg2    = rd2_q;
   assign rb_write_reg    = wr_reg_q;
   assign rb_write_data   = wr_data_q;
   assign rb_write_enable = we_q;

endmodule

// File: tb/tb_regbank_master.sv
// Bench for regbank_master: a behavioural 16x32 bank as responder plus a
// scoreboard of expected response beats popped on each handshake.
module tb_regbank_master;
   import regbank_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  idx;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_ra, cmd_rb;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_last;
   logic [31:0] rsp_data_a, rsp_data_b;
   logic [3:0]  rsp_idx;
   logic [3:0]  rb_read_reg1, rb_read_reg2, rb_write_reg;
   logic [31:0] rb_data_out1, rb_data_out2, rb_write_data;
   logic        rb_write_enable;

   logic [31:0] bank [16];
   logic [31:0] mdl [16];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   int          we_cycles = 0;

   always #5 clk = ~clk;

   regbank_master #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
      .rsp_idx(rsp_idx), .rsp_last(rsp_last),
      .rb_read_reg1(rb_read_reg1), .rb_read_reg2(rb_read_reg2),
      .rb_data_out1(rb_data_out1), .rb_data_out2(rb_data_out2),
      .rb_write_reg(rb_write_reg), .rb_write_data(rb_write_data),
      .rb_write_enable(rb_write_enable)
   );

   // Bank contents survive rst_n so an aborted write can be observed as absent.
   initial begin
      for (int i = 0; i < 16; i++) begin
         bank[i] = (i == 15) ? 32'd0 : 32'(10 * i);
         mdl[i]  = (i == 15) ? 32'd0 : 32'(10 * i);
      end
      forever begin
         @(posedge clk);
         if (rb_write_enable) bank[rb_write_reg] = rb_write_data;
      end
   end

   assign rb_data_out1 = bank[rb_read_reg1];
   assign rb_data_out2 = bank[rb_read_reg2];

   always @(negedge clk) if (rb_write_enable) we_cycles++;

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got beat a=%h b=%h idx=%0d, required none", rsp_data_a, rsp_data_b, rsp_idx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (rsp_data_a !== e.a || rsp_data_b !== e.b || rsp_idx !== e.idx || rsp_last !== e.last) begin
               errors++;
               $display("FAIL sb_beat: got a=%h b=%h idx=%0d last=%b, required a=%h b=%h idx=%0d last=%b",
                        rsp_data_a, rsp_data_b, rsp_idx, rsp_last, e.a, e.b, e.idx, e.last);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [31:0] wd);
      bit ok = 0;
      cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_wdata = wd; cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL cmd_accept_timeout: got cmd_ready=0, required 1 within 100 cycles");
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = OP_NOP;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && cmd_ready && !rsp_valid) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending beats, required 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic push_dump();
      for (int j = 0; j < 8; j++)
         sb.push_back('{a: mdl[2*j], b: mdl[2*j+1], idx: 4'(2*j), last: (j == 7)});
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_ra = '0; cmd_rb = '0; cmd_wdata = '0; rsp_ready = 1'b1;
      #2;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rb_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got ready=%b valid=%b last=%b we=%b, required 1 0 0 0", cmd_ready, rsp_valid, rsp_last, rb_write_enable);
      end
      checks++;
      if (rsp_data_a !== 32'd0 || rsp_data_b !== 32'd0 || rsp_idx !== 4'd0) begin
         errors++;
         $display("FAIL reset_rsp: got a=%h b=%h idx=%0d, required 0 0 0", rsp_data_a, rsp_data_b, rsp_idx);
      end
      checks++;
      if (rb_read_reg1 !== 4'd0 || rb_read_reg2 !== 4'd0 || rb_write_reg !== 4'd0 || rb_write_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_bank_ports: got r1=%0d r2=%0d wr=%0d wd=%h, required all 0", rb_read_reg1, rb_read_reg2, rb_write_reg, rb_write_data);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_read2();
      sb.push_back('{a: mdl[1], b: mdl[14], idx: 4'd1, last: 1'b1});
      send_cmd(OP_READ2, 4'd1, 4'd14, 32'd0);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL read2_accept_cycle: got valid=%b ready=%b, required 0 0", rsp_valid, cmd_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data_a !== 32'd10 || rsp_data_b !== 32'd140 || rsp_idx !== 4'd1 || rsp_last !== 1'b1) begin
         errors++;
         $display("FAIL read2_rsp: got v=%b a=%0d b=%0d idx=%0d last=%b, required 1 10 140 1 1", rsp_valid, rsp_data_a, rsp_data_b, rsp_idx, rsp_last);
      end
      drain();
   endtask

   task automatic test_write();
      int base = we_cycles;
      sb.push_back('{a: 32'hDEADBEEF, b: 32'd0, idx: 4'd3, last: 1'b1});
      mdl[3] = 32'hDEADBEEF;
      send_cmd(OP_WRITE, 4'd3, 4'd0, 32'hDEADBEEF);
      checks++;
      if (rb_write_enable !== 1'b1 || rb_write_reg !== 4'd3 || rb_write_data !== 32'hDEADBEEF || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL write_strobe: got we=%b wr=%0d wd=%h v=%b, required 1 3 deadbeef 0", rb_write_enable, rb_write_reg, rb_write_data, rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (rb_write_enable !== 1'b0 || bank[3] !== 32'hDEADBEEF || rsp_valid !== 1'b1 || rsp_data_a !== 32'hDEADBEEF || rsp_data_b !== 32'd0) begin
         errors++;
         $display("FAIL write_rsp: got we=%b bank3=%h v=%b a=%h b=%h, required 0 deadbeef 1 deadbeef 0", rb_write_enable, bank[3], rsp_valid, rsp_data_a, rsp_data_b);
      end
      sb.push_back('{a: mdl[3], b: mdl[15], idx: 4'd3, last: 1'b1});
      send_cmd(OP_READ2, 4'd3, 4'd15, 32'd0);
      drain();
      checks++;
      if (we_cycles - base !== 1) begin
         errors++;
         $display("FAIL write_enable_cycles: got %0d, required 1", we_cycles - base);
      end
   endtask

   task automatic test_dump();
      mdl[0] = 32'd5;
      sb.push_back('{a: 32'd5, b: 32'd0, idx: 4'd0, last: 1'b1});
      send_cmd(OP_WRITE, 4'd0, 4'd0, 32'd5);
      drain();
      push_dump();
      send_cmd(OP_DUMP, 4'd0, 4'd0, 32'd0);
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_idx !== 4'(2*j) || rsp_last !== (j == 7)) begin
            errors++;
            $display("FAIL dump_beat_timing: beat %0d got v=%b idx=%0d last=%b, required 1 %0d %b", j, rsp_valid, rsp_idx, rsp_last, 2*j, (j == 7));
         end
         if (j == 0 || j == 7) begin
            checks++;
            if (rsp_data_a !== ((j == 0) ? 32'd5 : 32'd140) || rsp_data_b !== ((j == 0) ? 32'd10 : 32'd0)) begin
               errors++;
               $display("FAIL dump_beat_data: beat %0d got a=%0d b=%0d", j, rsp_data_a, rsp_data_b);
            end
         end
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0 || cmd_ready !== (j == 7)) begin
            errors++;
            $display("FAIL dump_gap: beat %0d got v=%b ready=%b, required 0 %b", j, rsp_valid, cmd_ready, (j == 7));
         end
      end
      drain();
   endtask

   task automatic test_dump_stall();
      logic [31:0] pa, pb;
      logic [3:0]  pidx;
      logic        pl, pv, pr, have;
      int          hs = 0;
      bit          cr_bad = 0;
      have = 0; pv = 0; pr = 0; pa = '0; pb = '0; pidx = '0; pl = 0;
      rsp_ready = 1'b0;
      push_dump();
      send_cmd(OP_DUMP, 4'd0, 4'd0, 32'd0);
      for (int c = 0; c < 100; c++) begin
         if (have && pv && !pr) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data_a !== pa || rsp_data_b !== pb || rsp_idx !== pidx || rsp_last !== pl) begin
               errors++;
               $display("FAIL stall_hold: got v=%b a=%h b=%h idx=%0d last=%b, required 1 %h %h %0d %b", rsp_valid, rsp_data_a, rsp_data_b, rsp_idx, rsp_last, pa, pb, pidx, pl);
            end
         end
         if (have && pv && pr) hs++;
         if (hs == 8) break;
         if (cmd_ready) cr_bad = 1;
         pv = rsp_valid; pa = rsp_data_a; pb = rsp_data_b; pidx = rsp_idx; pl = rsp_last;
         rsp_ready = ~rsp_ready; pr = rsp_ready; have = 1;
         @(posedge clk); #1;
      end
      checks++;
      if (hs != 8 || cr_bad || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_handshakes: got hs=%0d early_ready=%0d ready=%b, required 8 0 1", hs, cr_bad, cmd_ready);
      end
      rsp_ready = 1'b1;
      drain();
   endtask

   task automatic test_nop_read();
      cmd_op = OP_NOP; cmd_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL nop_no_rsp: got ready=%b v=%b, required 1 0", cmd_ready, rsp_valid);
      end
      sb.push_back('{a: mdl[2], b: mdl[2], idx: 4'd2, last: 1'b1});
      cmd_op = OP_READ2; cmd_ra = 4'd2; cmd_rb = 4'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = OP_NOP;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data_a !== 32'd20 || rsp_data_b !== 32'd20) begin
         errors++;
         $display("FAIL nop_read2: got v=%b a=%0d b=%0d, required 1 20 20", rsp_valid, rsp_data_a, rsp_data_b);
      end
      drain();
   endtask

   task automatic test_reset_mid_dump();
      bit seen = 0;
      push_dump();
      send_cmd(OP_DUMP, 4'd0, 4'd0, 32'd0);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         if (j < 3) begin @(posedge clk); #1; end
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_idx !== 4'd6) begin
         errors++;
         $display("FAIL mid_dump_beat3: got v=%b idx=%0d, required 1 6", rsp_valid, rsp_idx);
      end
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data_a !== 32'd0 || rsp_idx !== 4'd0 || rb_read_reg1 !== 4'd0 || rb_read_reg2 !== 4'd0) begin
         errors++;
         $display("FAIL mid_dump_reset: got v=%b ready=%b a=%h idx=%0d r1=%0d r2=%0d, required 0 1 0 0 0 0", rsp_valid, cmd_ready, rsp_data_a, rsp_idx, rb_read_reg1, rb_read_reg2);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (rsp_valid || !cmd_ready) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_dump_abandon: got further beat or busy after reset, required idle");
      end
   endtask

   task automatic test_reset_mid_write();
      send_cmd(OP_WRITE, 4'd7, 4'd0, 32'h12345678);
      checks++;
      if (rb_write_enable !== 1'b1) begin
         errors++;
         $display("FAIL mid_write_strobe: got we=%b, required 1", rb_write_enable);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (rb_write_enable !== 1'b0 || rb_write_reg !== 4'd0 || rb_write_data !== 32'd0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_write_reset: got we=%b wr=%0d wd=%h ready=%b v=%b, required 0 0 0 1 0", rb_write_enable, rb_write_reg, rb_write_data, cmd_ready, rsp_valid);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if (bank[7] !== 32'd70) begin
         errors++;
         $display("FAIL mid_write_bank: got R7=%h, required %h", bank[7], 32'd70);
      end
      sb.push_back('{a: mdl[7], b: mdl[7], idx: 4'd7, last: 1'b1});
      send_cmd(OP_READ2, 4'd7, 4'd7, 32'd0);
      drain();
   endtask

   initial begin
      test_reset();
      test_read2();
      test_write();
      test_dump();
      test_dump_stall();
      test_nop_read();
      test_reset_mid_dump();
      test_reset_mid_write();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending beats, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
